// File: rtl/oculink_link_sequencer.sv
// Per-port PERST#/link bring-up sequencer for OCuLink root ports.
// Optional macro OCULINK_LINKDOWN_CNT_EN enables the per-port link-drop counters.
module oculink_link_sequencer #(
  parameter int NUM_PORTS       = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PERST_CYCLES    = 25000000,
  parameter int LINK_TIMEOUT    = 50000000,
  parameter int MAX_RETRY       = 3,
  parameter int CNT_W           = 32
) (
  input  logic                   user_clk,
  input  logic                   reset,
  input  logic [NUM_PORTS-1:0]   cprsnt,
  input  logic [NUM_PORTS-1:0]   sw_rst,
  input  logic [NUM_PORTS-1:0]   user_lnk_up,
  input  logic [NUM_PORTS-1:0]   finished_config,
  input  logic [NUM_PORTS-1:0]   failed_config,
  output logic [NUM_PORTS-1:0]   perst_n,
  output logic [NUM_PORTS-1:0]   start_config,
  output logic [NUM_PORTS-1:0]   port_ready,
  output logic [3*NUM_PORTS-1:0] port_state,
  output logic [4*NUM_PORTS-1:0] retry_cnt,
  output logic [8*NUM_PORTS-1:0] linkdown_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEBOUNCE  = 3'd1,
    PERST     = 3'd2,
    WAIT_LINK = 3'd3,
    CONFIG    = 3'd4,
    READY     = 3'd5,
    FAILED    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERST_LAST = CNT_W'(PERST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LINK_LAST  = CNT_W'(LINK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       RETRY_LIM  = 4'(MAX_RETRY);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic             sync_a;
    logic             sync_b;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_d;
    logic [3:0]       retry_q;
    logic [3:0]       retry_d;
    logic [3:0]       retry_inc;
    logic             retry_ok;
    logic             enter;
    logic             perst_n_q;
    logic             start_q;
    logic             ready_q;

    always_ff @(posedge user_clk) begin
      if (reset) begin
        sync_a <= 1'b0;
        sync_b <= 1'b0;
      end else begin
        sync_a <= cprsnt[p];
        sync_b <= sync_a;
      end
    end

    assign retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
    assign retry_ok  = (retry_q < RETRY_LIM);

    // Cable removal beats sw_rst, which beats every in-state transition.
    always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      enter   = 1'b0;
      if (state_q != IDLE && !sync_b) begin
        state_d = IDLE;
        retry_d = 4'd0;
        enter   = 1'b1;
      end else if (sw_rst[p] && state_q != IDLE && state_q != DEBOUNCE) begin
        state_d = PERST;
        retry_d = 4'd1;
        enter   = 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (sync_b) begin
              state_d = DEBOUNCE;
              enter   = 1'b1;
            end
          end
          DEBOUNCE: begin
            if (timer_q == DEB_LAST) begin
              state_d = PERST;
              retry_d = 4'd1;
              enter   = 1'b1;
            end
          end
          PERST: begin
            if (timer_q == PERST_LAST) begin
              state_d = WAIT_LINK;
              enter   = 1'b1;
            end
          end
          WAIT_LINK: begin
            if (user_lnk_up[p]) begin
              state_d = CONFIG;
              enter   = 1'b1;
            end else if (timer_q == LINK_LAST) begin
              enter = 1'b1;
              if (retry_ok) begin
                state_d = PERST;
                retry_d = retry_inc;
              end else begin
                state_d = FAILED;
              end
            end
          end
          CONFIG: begin
            if (failed_config[p]) begin
              state_d = FAILED;
              enter   = 1'b1;
            end else if (finished_config[p]) begin
              state_d = READY;
              enter   = 1'b1;
            end else if (!user_lnk_up[p]) begin
              enter = 1'b1;
              if (retry_ok) begin
                state_d = PERST;
                retry_d = retry_inc;
              end else begin
                state_d = FAILED;
              end
            end
          end
          READY: begin
            if (!user_lnk_up[p]) begin
              state_d = PERST;
              retry_d = 4'd1;
              enter   = 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (enter)
        timer_d = '0;
      else if (state_q == DEBOUNCE || state_q == PERST || state_q == WAIT_LINK)
        timer_d = timer_q + CNT_ONE;
      else
        timer_d = timer_q;
    end

    // Outputs decode the next state so they move together with port_state.
    always_ff @(posedge user_clk) begin
      if (reset) begin
        state_q   <= IDLE;
        timer_q   <= '0;
        retry_q   <= 4'd0;
        perst_n_q <= 1'b0;
        start_q   <= 1'b0;
        ready_q   <= 1'b0;
      end else begin
        state_q   <= state_d;
        timer_q   <= timer_d;
        retry_q   <= retry_d;
        perst_n_q <= (state_d == WAIT_LINK) || (state_d == CONFIG) || (state_d == READY);
        start_q   <= (state_d == CONFIG) && enter;
        ready_q   <= (state_d == READY);
      end
    end

    assign perst_n[p]             = perst_n_q;
    assign start_config[p]        = start_q;
    assign port_ready[p]          = ready_q;
    assign port_state[3*p +: 3]   = state_q;
    assign retry_cnt[4*p +: 4]    = retry_q;

`ifdef OCULINK_LINKDOWN_CNT_EN
    logic [7:0] linkdown_q;

    // Only a genuine link drop out of READY counts; sw_rst and cable loss do not.
    always_ff @(posedge user_clk) begin
      if (reset)
        linkdown_q <= 8'd0;
      else if (state_q == READY && sync_b && !sw_rst[p] && !user_lnk_up[p] && linkdown_q != 8'hFF)
        linkdown_q <= linkdown_q + 8'd1;
    end

    assign linkdown_cnt[8*p +: 8] = linkdown_q;
`else
    assign linkdown_cnt[8*p +: 8] = 8'd0;
`endif
  end

endmodule
